fifo_stream_drain: RTL and testbench
====================================

Name: fifo_stream_drain

Overview:
- Downstream consumer of the synchronous FIFO.
- Watches the FIFO empty flag and issues read enables. Captures each read word one cycle later into a 4-entry skid buffer.
- Presents the words as a valid/ready stream with packet framing (last flag) and a running beat counter.
- Full throughput (one beat per cycle) with no combinational path from out_Ready to fifo_Read_Enable.

Parameters:
- DATA_WIDTH, 8: width of FIFO words and out_Data.
- PACKET_LENGTH, 4: beats per packet; out_Last marks the final beat. Legal range 1..256.
- COUNT_WIDTH, 16: width of beat_Count.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high = may issue new FIFO reads; low = issue none, buffered data still drains.
- fifo_Empty  in  1  FIFO empty flag.
- fifo_Read_Enable  out  1  read request to FIFO.
- fifo_Data  in  DATA_WIDTH  FIFO read word; valid in the cycle after an accepted read.
- out_Valid  out  1  out_Data/out_Last valid.
- out_Ready  in  1  downstream accepts the beat.
- out_Data  out  DATA_WIDTH  stream data.
- out_Last  out  1  final beat of packet.
- beat_Count  out  COUNT_WIDTH  total beats transferred since reset; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (async assert, any time, including mid-stream):
  - Clears occupancy, read/write pointers, in-flight flag, packet position and beat_Count.
  - Buffer entries reset to 0.
  - Outputs: fifo_Read_Enable=0, out_Valid=0, out_Data=0, out_Last=0, beat_Count=0.
  - Any in-flight FIFO word is discarded. The FIFO pointer has already advanced, so that word is lost by design.
- Read issue (combinational): fifo_Read_Enable = enable & ~fifo_Empty & (occupancy + inflight < 4).
  - occupancy: 0..4, registered. inflight: 1 if a read was issued last cycle.
  - The issue decision never depends on out_Ready.
- Capture: when inflight=1, fifo_Data is written to buffer[wr_ptr] at the next rising edge and wr_ptr increments (2-bit, natural wrap).
- Latency: read issued in cycle t → word captured at the edge ending cycle t+1 → out_Valid=1 from cycle t+2.
- Output:
  - out_Valid = (occupancy != 0); out_Data = buffer[rd_ptr].
  - Handshake = out_Valid & out_Ready; on a handshake rd_ptr increments.
  - While out_Valid=1 and out_Ready=0, out_Data and out_Last hold stable.
- Occupancy update:
  - capture only → +1.
  - handshake only → −1.
  - both in the same cycle → unchanged.
  - Overflow is impossible by the issue rule; flag overflow with an assertion in simulation.
- Steady-state throughput: occupancy 1 + inflight 1 < 4, so a read issues every cycle while the FIFO is non-empty and out_Ready=1.
- Framing:
  - pkt_pos counter runs 0..PACKET_LENGTH-1 and advances on each handshake, wrapping to 0.
  - out_Last = out_Valid & (pkt_pos == PACKET_LENGTH-1).
  - With PACKET_LENGTH=1, out_Last=out_Valid.
- beat_Count: +1 per handshake, wraps from all-ones to 0.
- enable falling: no read issues in the same cycle. An in-flight word is still captured. Buffered words drain normally.
- fifo_Empty rising while a read is in flight: that word is still captured.

Decomposition:
- Shared package constants: SKID_DEPTH=4, SKID_PTR_WIDTH=2, default DATA_WIDTH=8.
- Sub-module stream_skid_buffer: 4-entry storage, wr/rd pointers, occupancy counter, out_Valid/out_Data.
- Issue logic, inflight flag, framing and beat_Count stay in fifo_stream_drain.

Test Plan:
- Reset: reset=0 then 1, fifo_Empty=1, enable=1 → fifo_Read_Enable=0, out_Valid=0, out_Data=0, beat_Count=0 for 20 cycles.
- Streaming: FIFO preloaded 0x10..0x17, out_Ready=1, enable=1 → fifo_Read_Enable high 8 consecutive cycles from t. out_Valid high cycles t+2..t+9 with data 0x10..0x17 in order. beat_Count=8.
- Backpressure: same preload, out_Ready=0 → exactly 4 reads, then fifo_Read_Enable=0. out_Data holds 0x10. Raise out_Ready → 0x10..0x17 delivered with no loss or duplication.
- Framing: PACKET_LENGTH=4, 8 beats → out_Last=1 only on 0x13 and 0x17. Insert random out_Ready gaps → same result.
- Enable gating: deassert enable after 3 reads issued → no further reads; 3 beats delivered. Reassert → remaining 5 beats delivered.
- Reset mid-stream: occupancy=3, one read in flight, pull reset low → out_Valid=0, beat_Count=0 immediately (asynchronous). After release, remaining FIFO words stream from pkt_pos=0.

Source files
------------

// File: rtl/fifo_stream_drain_pkg.sv
// fifo_stream_drain_pkg
//   Shared constants and types for the FIFO drain / skid buffer slice.
//   SKID_DEPTH      : entries in the output skid buffer
//   SKID_PTR_WIDTH  : read/write pointer width (natural wrap over SKID_DEPTH)
//   OCC_WIDTH       : occupancy counter width (must hold 0..SKID_DEPTH)
package fifo_stream_drain_pkg;
  localparam int SKID_DEPTH         = 4;
  localparam int SKID_PTR_WIDTH     = 2;
  localparam int OCC_WIDTH          = SKID_PTR_WIDTH + 1;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef logic [SKID_PTR_WIDTH-1:0] skid_ptr_t;
  typedef logic [OCC_WIDTH-1:0]      occ_t;

  // Width of a 0..len-1 position counter; a 1-beat packet still needs one bit.
  function automatic int pos_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction
endpackage

// File: rtl/fifo_stream_drain_if.sv
// fifo_stream_drain_if
//   Bundles the FIFO read side and the downstream valid/ready stream.
//   master : the drain (drives fifo_Read_Enable and the stream outputs)
//   slave  : the environment (FIFO + downstream consumer)
//   Signals: fifo_Empty, fifo_Read_Enable, fifo_Data,
//            out_Valid, out_Ready, out_Data, out_Last, beat_Count
interface fifo_stream_drain_if
  import fifo_stream_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = 16
) ();
  logic                   fifo_Empty;
  logic                   fifo_Read_Enable;
  logic [DATA_WIDTH-1:0]  fifo_Data;
  logic                   out_Valid;
  logic                   out_Ready;
  logic [DATA_WIDTH-1:0]  out_Data;
  logic                   out_Last;
  logic [COUNT_WIDTH-1:0] beat_Count;

  modport master (
    input  fifo_Empty, fifo_Data, out_Ready,
    output fifo_Read_Enable, out_Valid, out_Data, out_Last, beat_Count
  );

  modport slave (
    output fifo_Empty, fifo_Data, out_Ready,
    input  fifo_Read_Enable, out_Valid, out_Data, out_Last, beat_Count
  );
endinterface

// File: rtl/fifo_stream_drain_stream_skid_buffer.sv
// stream_skid_buffer
//   SKID_DEPTH-entry circular buffer between the FIFO read data and the
//   output stream.
//   clock, reset  : clock, async active-low reset
//   push_i        : write push_data_i at wr_ptr this edge
//   pop_i         : output beat accepted (valid & ready), advance rd_ptr
//   valid_o       : buffer non-empty
//   data_o        : entry at rd_ptr
//   occ_o         : current occupancy 0..SKID_DEPTH
module stream_skid_buffer
  import fifo_stream_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output occ_t                  occ_o
);
  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] buf_q;
  skid_ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  occ_t      occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Simultaneous push and pop leave occupancy unchanged.
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) buf_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign valid_o = (occ_q != '0);
  assign data_o  = buf_q[rd_ptr_q];
  assign occ_o   = occ_q;

  // The read-issue rule upstream reserves a slot for every in-flight word,
  // so a push into a full buffer means that rule is broken.
  ovf_a: assert property (@(posedge clock) disable iff (!reset)
    !(push_i && !pop_i && (occ_q == occ_t'(SKID_DEPTH))));
  udf_a: assert property (@(posedge clock) disable iff (!reset)
    !(pop_i && (occ_q == '0)));
endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
//   Drains a synchronous FIFO into a valid/ready stream with packet framing.
//   clock, reset : clock, async active-low reset
//   enable       : permit new FIFO reads (buffered data drains regardless)
//   bus (master) : fifo_Empty/fifo_Read_Enable/fifo_Data on the FIFO side,
//                  out_Valid/out_Ready/out_Data/out_Last/beat_Count downstream
//   Reads are issued whenever the skid buffer has room for the word plus any
//   word already in flight, so the issue path never looks at out_Ready.
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int PACKET_LENGTH = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input logic               clock,
  input logic               reset,
  input logic               enable,
  fifo_stream_drain_if.master bus
);
  localparam int             POS_W    = pos_width(PACKET_LENGTH);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PACKET_LENGTH - 1);

  logic                   inflight_q, inflight_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  occ_t                   occ, load;
  logic                   valid, hs, rd_en;
  logic [DATA_WIDTH-1:0]  data;

  // Slots already committed: stored words plus the one arriving next edge.
  assign load  = occ + occ_t'(inflight_q);
  // Gated by reset so no FIFO word is popped (and lost) while held in reset.
  assign rd_en = reset & enable & ~bus.fifo_Empty & (load < occ_t'(SKID_DEPTH));
  assign hs    = valid & bus.out_Ready;

  always_comb begin
    inflight_d = rd_en;
    pos_d      = pos_q;
    cnt_d      = cnt_q;
    if (hs) begin
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      pos_q      <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
    end
  end

  stream_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (bus.fifo_Data),
    .pop_i       (hs),
    .valid_o     (valid),
    .data_o      (data),
    .occ_o       (occ)
  );

  assign bus.fifo_Read_Enable = rd_en;
  assign bus.out_Valid        = valid;
  assign bus.out_Data         = data;
  assign bus.out_Last         = valid & (pos_q == POS_LAST);
  assign bus.beat_Count       = cnt_q;
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain
//   Directed bench: a small FIFO model feeds the drain; a per-cycle vector
//   table covers the streaming case, hand-written sequences cover
//   backpressure, random ready gaps, enable gating and mid-stream reset.
module tb_fifo_stream_drain;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  always #5 clock = ~clock;

  fifo_stream_drain_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) bus ();

  fifo_stream_drain #(.DATA_WIDTH(8), .PACKET_LENGTH(4), .COUNT_WIDTH(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  // FIFO model: word valid the cycle after an accepted read.
  logic [7:0] mem [64];
  logic [5:0] rd_idx = '0;
  logic [5:0] wr_cnt = '0;
  logic [7:0] fifo_dq = '0;

  assign bus.fifo_Empty = (rd_idx == wr_cnt);
  assign bus.fifo_Data  = fifo_dq;

  always @(posedge clock) begin
    if (bus.fifo_Read_Enable) begin
      fifo_dq <= mem[rd_idx];
      rd_idx  <= rd_idx + 6'd1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_cnt] = base + 8'(i);
      wr_cnt      = wr_cnt + 6'd1;
    end
  endtask

  logic [7:0] got_d[$];
  bit         got_l[$];
  int         n_reads;

  task automatic clear();
    got_d.delete();
    got_l.delete();
    n_reads = 0;
  endtask

  // Called just after a negedge; rmode 0: ready low, 1: ready high, 2: random.
  task automatic run(input int max_cyc, input int want, input bit en, input int rmode);
    for (int c = 0; c < max_cyc && got_d.size() < want; c++) begin
      enable        = en;
      bus.out_Ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
      #1;
      if (bus.fifo_Read_Enable === 1'b1) n_reads++;
      if (bus.out_Valid === 1'b1 && bus.out_Ready) begin
        got_d.push_back(bus.out_Data);
        got_l.push_back(bus.out_Last);
      end
      @(negedge clock);
    end
  endtask

  task automatic check_frame(input string tag, input int n, input logic [7:0] base);
    chk({tag, ".beats"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      chk($sformatf("%s.data[%0d]", tag, i), got_d[i], base + 8'(i));
      chk($sformatf("%s.last[%0d]", tag, i), got_l[i], ((i % 4) == 3));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    bus.out_Ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  typedef struct {
    bit         en;
    bit         rdy;
    bit         re;
    bit         v;
    logic [7:0] d;
    bit         l;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Streaming 0x10..0x17 with ready high; read issued cycle 0 -> valid cycle 2.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 16'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 16'd3};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 16'd4};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 16'd5};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h16, 1'b0, 16'd6};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 16'd7};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd8};

    bus.out_Ready = 1'b0;
    #1 reset = 1'b0;
    @(negedge clock);
    #1;
    chk("rst.assert.valid", bus.out_Valid, 0);
    chk("rst.assert.count", bus.beat_Count, 0);
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b1;

    // Reset state with an empty FIFO and enable high.
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("rst[%0d].re", i), bus.fifo_Read_Enable, 0);
      chk($sformatf("rst[%0d].valid", i), bus.out_Valid, 0);
      chk($sformatf("rst[%0d].data", i), bus.out_Data, 0);
      chk($sformatf("rst[%0d].count", i), bus.beat_Count, 0);
      @(negedge clock);
    end

    // Table-driven streaming.
    preload(8'h10, 8);
    for (int i = 0; i < 11; i++) begin
      enable        = tbl[i].en;
      bus.out_Ready = tbl[i].rdy;
      #1;
      chk($sformatf("stream[%0d].re", i), bus.fifo_Read_Enable, tbl[i].re);
      chk($sformatf("stream[%0d].valid", i), bus.out_Valid, tbl[i].v);
      if (tbl[i].v) chk($sformatf("stream[%0d].data", i), bus.out_Data, tbl[i].d);
      chk($sformatf("stream[%0d].last", i), bus.out_Last, tbl[i].l);
      chk($sformatf("stream[%0d].count", i), bus.beat_Count, tbl[i].cnt);
      @(negedge clock);
    end

    // Backpressure: exactly four reads fill the buffer, head word holds.
    do_reset();
    clear();
    preload(8'h10, 8);
    run(10, 1000, 1'b1, 0);
    chk("bp.reads_stalled", n_reads, 4);
    #1;
    chk("bp.valid", bus.out_Valid, 1);
    chk("bp.hold_data", bus.out_Data, 8'h10);
    chk("bp.re_low", bus.fifo_Read_Enable, 0);
    chk("bp.count", bus.beat_Count, 0);
    @(negedge clock);
    run(40, 8, 1'b1, 1);
    check_frame("bp", 8, 8'h10);
    chk("bp.reads_total", n_reads, 8);
    #1 chk("bp.count_end", bus.beat_Count, 8);
    @(negedge clock);

    // Framing under random ready gaps.
    do_reset();
    clear();
    preload(8'h10, 8);
    run(400, 8, 1'b1, 2);
    check_frame("frame_rand", 8, 8'h10);

    // Enable gating: three reads, then enable low; in-flight word still lands.
    do_reset();
    clear();
    preload(8'h10, 8);
    run(3, 1000, 1'b1, 1);
    chk("en.reads_on", n_reads, 3);
    run(10, 1000, 1'b0, 1);
    chk("en.reads_off", n_reads, 3);
    chk("en.beats_off", got_d.size(), 3);
    run(40, 8, 1'b1, 1);
    chk("en.reads_total", n_reads, 8);
    check_frame("en", 8, 8'h10);

    // Mid-stream reset with occupancy 3 and one read in flight.
    do_reset();
    clear();
    preload(8'h40, 12);
    run(4, 1000, 1'b1, 1);
    run(2, 1000, 1'b1, 0);
    chk("mid.reads", n_reads, 6);
    enable = 1'b1;
    bus.out_Ready = 1'b0;
    #1;
    chk("mid.pre.valid", bus.out_Valid, 1);
    chk("mid.pre.data", bus.out_Data, 8'h42);
    chk("mid.pre.re_full", bus.fifo_Read_Enable, 0);
    chk("mid.pre.count", bus.beat_Count, 2);
    reset = 1'b0;
    #1;
    chk("mid.rst.valid", bus.out_Valid, 0);
    chk("mid.rst.count", bus.beat_Count, 0);
    chk("mid.rst.data", bus.out_Data, 0);
    chk("mid.rst.last", bus.out_Last, 0);
    chk("mid.rst.re", bus.fifo_Read_Enable, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear();
    run(40, 6, 1'b1, 1);
    check_frame("mid.after", 6, 8'h46);
    #1;
    chk("mid.after.count", bus.beat_Count, 6);
    chk("mid.fifo_drained", bus.fifo_Empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
